barrett_mod_mul_pipe: RTL and testbench

Fully pipelined Barrett modular multiplier that computes r = a*b mod s and sustains one result per clock. It is the parametrised successor of the single-stage modmul. Modulus s and Barrett constant m travel with each operand pair, so consecutive transactions may use different moduli. A tag is carried alongside each operation, and a valid/ready handshake on both sides supports backpressure from the MSM datapath.

---
 rtl/barrett_mod_mul_pipe_if.sv | 28 ++
 rtl/barrett_mod_mul_pipe.sv | 126 ++++++++++++
 tb/tb_barrett_mod_mul_pipe.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrett_mod_mul_pipe_if.sv
// Operand/result handshake bundle for barrett_mod_mul_pipe; master drives operands, slave is the multiplier.
interface barrett_mod_mul_pipe_if #(
   parameter int FIELD_WIDTH = 16,
   parameter int TAG_WIDTH   = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [FIELD_WIDTH-1:0] a;
   logic [FIELD_WIDTH-1:0] b;
   logic [FIELD_WIDTH-1:0] s;
   logic [FIELD_WIDTH:0]   m;
   logic [TAG_WIDTH-1:0]   in_tag;
   logic                   out_valid;
   logic                   out_ready;
   logic [FIELD_WIDTH-1:0] r;
   logic [TAG_WIDTH-1:0]   out_tag;
   logic [2:0]             in_flight;

   modport master (
      output in_valid, a, b, s, m, in_tag, out_ready,
      input  in_ready, out_valid, r, out_tag, in_flight
   );

   modport slave (
      input  in_valid, a, b, s, m, in_tag, out_ready,
      output in_ready, out_valid, r, out_tag, in_flight
   );
endinterface

// File: rtl/barrett_mod_mul_pipe.sv
// Barrett modular multiplier r = a*b mod s, 4 register stages, 4-clock latency, one result per clock.
// A held output (out_valid && !out_ready) freezes every stage including bubbles; in_ready follows that stall only.
module barrett_mod_mul_pipe #(
   parameter int FIELD_WIDTH = 16,
   parameter int TAG_WIDTH   = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   barrett_mod_mul_pipe_if.slave bus
);
   localparam int N = FIELD_WIDTH;
   localparam int T = TAG_WIDTH;

   typedef struct packed {
      logic [2*N-1:0] x;
      logic [N-1:0]   s;
      logic [N:0]     m;
      logic [T-1:0]   tag;
   } s1_t;

   typedef struct packed {
      logic [N+1:0] x;
      logic [N:0]   q;
      logic [N-1:0] s;
      logic [T-1:0] tag;
   } s2_t;

   typedef struct packed {
      logic [N+1:0] r0;
      logic [N-1:0] s;
      logic [T-1:0] tag;
   } s3_t;

   typedef struct packed {
      logic [N-1:0] r;
      logic [T-1:0] tag;
   } s4_t;

   logic         advance;
   logic         accept;
   logic         v1_q, v2_q, v3_q, v4_q;
   s1_t          s1_q, s1_d;
   s2_t          s2_q, s2_d;
   s3_t          s3_q, s3_d;
   s4_t          s4_q, s4_d;
   logic [2:0]   in_flight_q, in_flight_d;
   logic [N+1:0] qs_lo;
   logic [N+1:0] sx1, sx2, sx3;
   logic [N+1:0] sub_sel;

   assign advance      = !v4_q || bus.out_ready;
   assign accept       = bus.in_valid && advance;
   assign bus.in_ready = advance;

   always_comb begin
      s1_d.x   = {{N{1'b0}}, bus.a} * {{N{1'b0}}, bus.b};
      s1_d.s   = bus.s;
      s1_d.m   = bus.m;
      s1_d.tag = bus.in_tag;
   end

   // Only the low n+2 bits of x matter once the remainder is known to be below 4s.
   always_comb begin
      s2_d.x   = s1_q.x[N+1:0];
      s2_d.q   = (N+1)'(({{(N+1){1'b0}}, s1_q.x[2*N-1:N]} * {{N{1'b0}}, s1_q.m}) >> N);
      s2_d.s   = s1_q.s;
      s2_d.tag = s1_q.tag;
   end

   assign qs_lo = {1'b0, s2_q.q} * {2'b00, s2_q.s};

   always_comb begin
      s3_d.r0  = s2_q.x - qs_lo;
      s3_d.s   = s2_q.s;
      s3_d.tag = s2_q.tag;
   end

   assign sx1 = {2'b00, s3_q.s};
   assign sx2 = {1'b0, s3_q.s, 1'b0};
   assign sx3 = sx1 + sx2;

   always_comb begin
      sub_sel = '0;
      if (s3_q.r0 >= sx3) begin
         sub_sel = sx3;
      end else if (s3_q.r0 >= sx2) begin
         sub_sel = sx2;
      end else if (s3_q.r0 >= sx1) begin
         sub_sel = sx1;
      end
      s4_d.r   = N'(s3_q.r0 - sub_sel);
      s4_d.tag = s3_q.tag;
   end

   // After an advancing edge the valid bits are {accept, v1, v2, v3}.
   assign in_flight_d = 3'(accept) + 3'(v1_q) + 3'(v2_q) + 3'(v3_q);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         v4_q        <= 1'b0;
         s1_q        <= '0;
         s2_q        <= '0;
         s3_q        <= '0;
         s4_q        <= '0;
         in_flight_q <= '0;
      end else if (advance) begin
         v1_q        <= accept;
         v2_q        <= v1_q;
         v3_q        <= v2_q;
         v4_q        <= v3_q;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         s3_q        <= s3_d;
         s4_q        <= s4_d;
         in_flight_q <= in_flight_d;
      end
   end

   assign bus.out_valid = v4_q;
   assign bus.r         = s4_q.r;
   assign bus.out_tag   = s4_q.tag;
   assign bus.in_flight = in_flight_q;
endmodule

// File: tb/tb_barrett_mod_mul_pipe.sv
// Directed and random-soak bench for barrett_mod_mul_pipe against a queue-based a*b mod s model.
module tb_barrett_mod_mul_pipe;
   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   done_flag = 1'b0;

   typedef struct {
      logic [15:0] r;
      logic [7:0]  tag;
   } exp_t;

   exp_t        expq[$];
   logic [15:0] log_r[$];
   logic [7:0]  log_tag[$];
   int          log_cyc[$];

   barrett_mod_mul_pipe_if bus ();

   barrett_mod_mul_pipe dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint got, input longint exp_v);
      tests++;
      if (got !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp_v, cyc);
      end
   endtask

   // Scoreboard: everything accepted and not yet consumed is in flight.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         expq.delete();
      end else begin
         chk("in_flight", bus.in_flight, expq.size());
         chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
         if (bus.out_valid && bus.out_ready) begin
            tests++;
            if (expq.size() == 0) begin
               fails++;
               $display("FAIL spurious_out: got r=%0d tag=%0d, expected no output", bus.r, bus.out_tag);
            end else begin
               e = expq.pop_front();
               chk("r", bus.r, e.r);
               chk("out_tag", bus.out_tag, e.tag);
            end
            log_r.push_back(bus.r);
            log_tag.push_back(bus.out_tag);
            log_cyc.push_back(cyc);
         end
         if (bus.in_valid && bus.in_ready) begin
            longint unsigned p;
            p     = longint'(bus.a) * longint'(bus.b);
            e.r   = 16'(p % longint'(bus.s));
            e.tag = bus.in_tag;
            expq.push_back(e);
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                       input logic [16:0] m, input logic [7:0] tag);
      bit ok;
      int n;
      n  = 0;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.s        = s;
      bus.m        = m;
      bus.in_tag   = tag;
      do begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 300);
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while ((expq.size() != 0 || bus.out_valid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_done", expq.size(), 0);
   endtask

   function automatic logic [16:0] barrett_m(input logic [15:0] s);
      longint unsigned q;
      q = (64'd1 << 32) / longint'(s);
      return 17'(q);
   endfunction

   initial begin
      logic [15:0] str_a [6];
      logic [15:0] str_b [6];
      logic [15:0] str_r [6];
      int n;
      int seen;
      str_a = '{16'd32770, 16'd12345, 16'd1, 16'd2,     16'd100, 16'd32770};
      str_b = '{16'd32770, 16'd0,     16'd1, 16'd16386, 16'd200, 16'd2};
      str_r = '{16'd1,     16'd0,     16'd1, 16'd1,     16'd20000, 16'd32769};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.s         = '0;
      bus.m         = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_r", bus.r, 0);
      chk("rst_out_tag", bus.out_tag, 0);
      chk("rst_in_flight", bus.in_flight, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      reset = 1'b0;

      // Fill the pipe behind a stalled output, then reset it mid-operation.
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'd100, 16'(i + 1), 16'd32771, 17'd131060, 8'(8'hA0 + i));
      bus.in_valid = 1'b0;
      chk("full_in_flight", bus.in_flight, 4);
      chk("full_out_valid", bus.out_valid, 1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_in_flight", bus.in_flight, 0);
      chk("midrst_r", bus.r, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      bus.out_ready = 1'b1;
      seen = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      chk("post_reset_quiet", seen, 0);

      // Single op latency and literal result.
      send(16'd65520, 16'd65520, 16'd65521, 17'd65551, 8'h11);
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency_edges", n, 4);
      chk("single_r", bus.r, 1);
      chk("single_tag", bus.out_tag, 8'h11);
      drain();

      // Back-to-back stream, one modulus.
      log_r.delete(); log_tag.delete(); log_cyc.delete();
      for (int i = 0; i < 6; i++) send(str_a[i], str_b[i], 16'd32771, 17'd131060, 8'(i));
      drain();
      chk("stream_count", log_r.size(), 6);
      if (log_r.size() == 6) begin
         for (int i = 0; i < 6; i++) begin
            chk("stream_r", log_r[i], str_r[i]);
            chk("stream_tag", log_tag[i], i);
         end
         chk("stream_rate", log_cyc[5] - log_cyc[0], 5);
      end

      // Mixed moduli in consecutive cycles.
      log_r.delete(); log_tag.delete(); log_cyc.delete();
      send(16'd65520, 16'd2, 16'd65521, barrett_m(16'd65521), 8'h40);
      send(16'd32770, 16'd2, 16'd32771, barrett_m(16'd32771), 8'h41);
      drain();
      chk("mixed_count", log_r.size(), 2);
      if (log_r.size() == 2) begin
         chk("mixed_r0", log_r[0], 65519);
         chk("mixed_r1", log_r[1], 32769);
         chk("mixed_consecutive", log_cyc[1] - log_cyc[0], 1);
      end

      // Backpressure: hold out_ready low for 5 cycles once the first result shows.
      log_r.delete(); log_tag.delete(); log_cyc.delete();
      fork
         begin
            for (int i = 0; i < 6; i++) send(str_a[i], str_b[i], 16'd32771, 17'd131060, 8'(8'h20 + i));
            bus.in_valid = 1'b0;
         end
         begin
            n = 0;
            while (!bus.out_valid && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            bus.out_ready = 1'b0;
            repeat (2) begin
               @(posedge clk);
               #1;
            end
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_in_flight", bus.in_flight, 4);
            repeat (3) begin
               @(posedge clk);
               #1;
            end
            bus.out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_count", log_r.size(), 6);
      if (log_r.size() == 6) begin
         for (int i = 0; i < 6; i++) begin
            chk("bp_r", log_r[i], str_r[i]);
            chk("bp_tag", log_tag[i], 8'h20 + i);
         end
      end

      // Random soak with random output backpressure.
      log_r.delete(); log_tag.delete(); log_cyc.delete();
      done_flag = 1'b0;
      fork
         begin
            for (int i = 0; i < 2000; i++) begin
               logic [15:0] rs;
               logic [15:0] ra;
               logic [15:0] rb;
               rs = 16'($urandom_range(32769, 65535));
               ra = 16'($urandom_range(0, int'(rs) - 1));
               rb = 16'($urandom_range(0, int'(rs) - 1));
               send(ra, rb, rs, barrett_m(rs), 8'(i));
               if ($urandom_range(0, 3) == 0) begin
                  bus.in_valid = 1'b0;
                  @(posedge clk);
                  #1;
               end
            end
            bus.in_valid = 1'b0;
            done_flag = 1'b1;
         end
         begin
            while (!done_flag) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 9) < 7);
            end
         end
      join
      drain();
      chk("soak_count", log_r.size(), 2000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      fails++;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
